// File: rtl/minbd_permute_stage.sv
// MinBD router datapath: registered eject/inject stage, then a registered two-level
// 2x2 permutation network. Define MINBD_AGE_EN for age-based priority and aging.
module minbd_permute_stage #(
    parameter int FLIT_W   = 16,
    parameter int COORD_W  = 2,
    parameter int AGE_W    = 3,
    parameter int ROUTER_X = 1,
    parameter int ROUTER_Y = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] nty,
    input  logic [FLIT_W-1:0] ety,
    input  logic [FLIT_W-1:0] sty,
    input  logic [FLIT_W-1:0] wty,
    output logic [FLIT_W-1:0] nxt,
    output logic [FLIT_W-1:0] ext,
    output logic [FLIT_W-1:0] sxt,
    output logic [FLIT_W-1:0] wxt,
    input  logic              inj_valid,
    input  logic [FLIT_W-1:0] inj_flit,
    output logic              inj_ready,
    output logic              ej_valid,
    output logic [FLIT_W-1:0] ej_flit,
    output logic [15:0]       defl_cnt
);
    localparam int PAY_W = FLIT_W - 1 - 2 * COORD_W - AGE_W;
    localparam int VB    = FLIT_W - 1;
    localparam int YL    = VB - COORD_W;
    localparam int XL    = YL - COORD_W;
    localparam int AL    = XL - AGE_W;
    localparam logic [COORD_W-1:0] RX = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] RY = COORD_W'(ROUTER_Y);
    localparam logic [2:0] DIR_N = 3'd0;
    localparam logic [2:0] DIR_S = 3'd2;
    localparam logic [2:0] DIR_E = 3'd1;
    localparam logic [2:0] DIR_W = 3'd3;
    localparam logic [2:0] DIR_L = 3'd4;

    typedef logic [FLIT_W-1:0] flit_t;

    generate
        if (PAY_W < 1) begin : g_width_check
            $error("minbd_permute_stage: FLIT_W leaves no payload bits");
        end
    endgenerate

    function automatic logic [2:0] prodDir(input flit_t f);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dy = f[YL +: COORD_W];
        dx = f[XL +: COORD_W];
        if (dx > RX)      prodDir = DIR_E;
        else if (dx < RX) prodDir = DIR_W;
        else if (dy > RY) prodDir = DIR_N;
        else if (dy < RY) prodDir = DIR_S;
        else              prodDir = DIR_L;
    endfunction

    // In placement, a local-destined flit ranks below any productive flit.
    function automatic logic beats(input flit_t a, input logic [1:0] ia,
                                   input flit_t b, input logic [1:0] ib,
                                   input logic [1:0] ptr, input logic place);
        logic [1:0] ra;
        logic [1:0] rb;
        logic       la;
        logic       lb;
        ra = ia - ptr;
        rb = ib - ptr;
        la = (prodDir(a) == DIR_L);
        lb = (prodDir(b) == DIR_L);
        if (a[VB] != b[VB])                        beats = a[VB];
        else if (place && a[VB] && (la != lb))     beats = lb;
`ifdef MINBD_AGE_EN
        else if (a[VB] && (a[AL +: AGE_W] != b[AL +: AGE_W]))
                                                   beats = a[AL +: AGE_W] > b[AL +: AGE_W];
        else if (a[VB])                            beats = ia < ib;
`endif
        else                                       beats = ra < rb;
    endfunction

    flit_t       inA [4];
    flit_t       slotA_d [4];
    flit_t       slotA_q [4];
    flit_t       out_d [4];
    flit_t       out_q [4];
    flit_t       ejFlit_d, ejFlit_q, injFlit;
    logic        ejValid_d, ejValid_q;
    logic [1:0]  ejIdx, injIdx;
    logic        injFree;
    logic [1:0]  rr_q;
    logic [15:0] defl_d, defl_q;

    assign inA[0] = nty;
    assign inA[1] = ety;
    assign inA[2] = sty;
    assign inA[3] = wty;

    always_comb begin
        slotA_d   = '{default: '0};
        ejValid_d = 1'b0;
        ejIdx     = '0;
        injIdx    = '0;
        injFree   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (inA[i][VB]) slotA_d[i] = inA[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (slotA_d[i][VB] && (prodDir(slotA_d[i]) == DIR_L) &&
                (!ejValid_d || beats(slotA_d[i], 2'(i), slotA_d[ejIdx], ejIdx, rr_q, 1'b0))) begin
                ejValid_d = 1'b1;
                ejIdx     = 2'(i);
            end
        end
        ejFlit_d = ejValid_d ? slotA_d[ejIdx] : '0;
        if (ejValid_d) slotA_d[ejIdx] = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!slotA_d[i][VB]) begin
                injFree = 1'b1;
                injIdx  = 2'(i);
            end
        end
        injFlit              = inj_flit;
        injFlit[VB]          = 1'b1;
        injFlit[AL +: AGE_W] = '0;
        if (inj_valid && injFree) slotA_d[injIdx] = injFlit;
    end

    assign inj_ready = injFree;

    always_comb begin
        flit_t       a, b, win, los;
        flit_t       nsF [2];
        flit_t       ewF [2];
        logic [1:0]  ia, ib, wi, li;
        logic [1:0]  nsI [2];
        logic [1:0]  ewI [2];
        logic        toNs;
        logic [2:0]  nDefl;
        logic [16:0] cntSum;
        a = '0; b = '0; win = '0; los = '0;
        ia = '0; ib = '0; wi = '0; li = '0;
        nsF = '{default: '0}; ewF = '{default: '0};
        nsI = '{default: '0}; ewI = '{default: '0};
        out_d = '{default: '0};
        toNs = 1'b0;
        nDefl = '0;
        for (int p = 0; p < 2; p++) begin
            a  = slotA_q[2*p];
            b  = slotA_q[2*p+1];
            ia = 2'(2*p);
            ib = 2'(2*p+1);
            if (beats(a, ia, b, ib, rr_q, 1'b1)) begin
                win = a; wi = ia; los = b; li = ib;
            end else begin
                win = b; wi = ib; los = a; li = ia;
            end
            toNs   = win[VB] && ((prodDir(win) == DIR_N) || (prodDir(win) == DIR_S));
            nsF[p] = toNs ? win : los;
            nsI[p] = toNs ? wi : li;
            ewF[p] = toNs ? los : win;
            ewI[p] = toNs ? li : wi;
        end
        // Level-2 winner takes its productive port; anything else lands on the default side.
        if (beats(nsF[0], nsI[0], nsF[1], nsI[1], rr_q, 1'b1)) begin
            win = nsF[0]; los = nsF[1];
        end else begin
            win = nsF[1]; los = nsF[0];
        end
        if (prodDir(win) == DIR_S) begin
            out_d[2] = win; out_d[0] = los;
        end else begin
            out_d[0] = win; out_d[2] = los;
        end
        if (beats(ewF[0], ewI[0], ewF[1], ewI[1], rr_q, 1'b1)) begin
            win = ewF[0]; los = ewF[1];
        end else begin
            win = ewF[1]; los = ewF[0];
        end
        if (prodDir(win) == DIR_W) begin
            out_d[3] = win; out_d[1] = los;
        end else begin
            out_d[1] = win; out_d[3] = los;
        end
        for (int p = 0; p < 4; p++) begin
            if (out_d[p][VB] && (prodDir(out_d[p]) != 3'(p))) begin
                nDefl = nDefl + 3'd1;
`ifdef MINBD_AGE_EN
                if (out_d[p][AL +: AGE_W] != '1)
                    out_d[p][AL +: AGE_W] = out_d[p][AL +: AGE_W] + AGE_W'(1);
`endif
            end
        end
        cntSum = {1'b0, defl_q} + {14'b0, nDefl};
        defl_d = cntSum[16] ? 16'hFFFF : cntSum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= '0;
            ejValid_q <= 1'b0;
            ejFlit_q  <= '0;
            defl_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                slotA_q[i] <= '0;
                out_q[i]   <= '0;
            end
        end else begin
            rr_q      <= rr_q + 2'd1;
            ejValid_q <= ejValid_d;
            ejFlit_q  <= ejFlit_d;
            defl_q    <= defl_d;
            for (int i = 0; i < 4; i++) begin
                slotA_q[i] <= slotA_d[i];
                out_q[i]   <= out_d[i];
            end
        end
    end

    assign nxt      = out_q[0];
    assign ext      = out_q[1];
    assign sxt      = out_q[2];
    assign wxt      = out_q[3];
    assign ej_valid = ejValid_q;
    assign ej_flit  = ejFlit_q;
    assign defl_cnt = defl_q;
endmodule

// File: tb/tb_minbd_permute_stage.sv
// Scoreboard bench for minbd_permute_stage: directed vectors push expected results,
// a negedge monitor pops and compares whenever the DUT presents an eject or mesh output.
module tb_minbd_permute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nty, ety, sty, wty;
    logic [15:0] nxt, ext, sxt, wxt;
    logic        inj_valid;
    logic [15:0] inj_flit;
    logic        inj_ready;
    logic        ej_valid;
    logic [15:0] ej_flit;
    logic [15:0] defl_cnt;

    typedef struct {
        logic [15:0] n, e, s, w, defl;
    } meshExp_t;

    meshExp_t    meshQ [$];
    logic [15:0] ejQ [$];
    meshExp_t    monExp;
    logic [15:0] monEj;
    int          total = 0;
    int          bad = 0;
    logic        monOn = 1'b0;

    minbd_permute_stage dut (
        .clk(clk), .rst(rst),
        .nty(nty), .ety(ety), .sty(sty), .wty(wty),
        .nxt(nxt), .ext(ext), .sxt(sxt), .wxt(wxt),
        .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_flit(ej_flit), .defl_cnt(defl_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Flit built from destination (x, y), age and payload, valid set.
    function automatic logic [15:0] mk(input int x, input int y, input int age, input int pl);
        mk = {1'b1, 2'(y), 2'(x), 3'(age), 8'(pl)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pushMesh(input logic [15:0] n, e, s, w, d);
        meshExp_t m;
        m.n = n; m.e = e; m.s = s; m.w = w; m.defl = d;
        meshQ.push_back(m);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Called at a negedge; drives one cycle of inputs, then clears them.
    task automatic applyStimulus(input logic [15:0] n, e, s, w, input logic iv,
                                 input logic [15:0] ifl, input logic chkReady,
                                 input logic expReady, input string name);
        nty = n; ety = e; sty = s; wty = w;
        inj_valid = iv; inj_flit = ifl;
        #1;
        if (chkReady) checkOutput({name, "_inj_ready"}, inj_ready, expReady);
        @(negedge clk);
        nty = '0; ety = '0; sty = '0; wty = '0;
        inj_valid = 1'b0; inj_flit = '0;
    endtask

    task automatic resetDut(input string name);
        @(negedge clk);
        rst = 1'b1;
        nty = '0; ety = '0; sty = '0; wty = '0;
        inj_valid = 1'b0; inj_flit = '0;
        @(negedge clk);
        checkOutput({name, "_valids"}, {nxt[15], ext[15], sxt[15], wxt[15], ej_valid}, 0);
        checkOutput({name, "_defl"}, defl_cnt, 0);
        rst = 1'b0;
    endtask

    // Monitor: every presented eject or mesh output must match the head of its queue.
    always @(negedge clk) begin
        if (monOn) begin
            if (ej_valid === 1'b1) begin
                if (ejQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL eject_unexpected actual=%h expected=none", ej_flit);
                end else begin
                    monEj = ejQ.pop_front();
                    checkOutput("ej_flit", ej_flit, monEj);
                end
            end
            if ((nxt[15] | ext[15] | sxt[15] | wxt[15]) === 1'b1) begin
                if (meshQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL mesh_unexpected actual=%h_%h_%h_%h expected=none",
                             nxt, ext, sxt, wxt);
                end else begin
                    monExp = meshQ.pop_front();
                    checkOutput("mesh_nxt", nxt, monExp.n);
                    checkOutput("mesh_ext", ext, monExp.e);
                    checkOutput("mesh_sxt", sxt, monExp.s);
                    checkOutput("mesh_wxt", wxt, monExp.w);
                    checkOutput("mesh_defl", defl_cnt, monExp.defl);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        nty = '0; ety = '0; sty = '0; wty = '0;
        inj_valid = 1'b0; inj_flit = '0;

        // Single eastbound flit, no contention.
        resetDut("rst1");
        monOn = 1'b1;
        pushMesh(0, mk(2, 1, 0, 'h11), 0, 0, 0);
        applyStimulus(mk(2, 1, 0, 'h11), 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, "t1");
        idle(3);

        // Two local flits: one ejected, the other deflected east.
        resetDut("rst2");
`ifdef MINBD_AGE_EN
        ejQ.push_back(mk(1, 1, 5, 'h22));
        pushMesh(0, mk(1, 1, 3, 'h21), 0, 0, 1);
`else
        ejQ.push_back(mk(1, 1, 2, 'h21));
        pushMesh(0, mk(1, 1, 5, 'h22), 0, 0, 1);
`endif
        applyStimulus(mk(1, 1, 2, 'h21), 0, mk(1, 1, 5, 'h22), 0, 1'b0, 0, 1'b0, 1'b0, "t2");
        idle(3);

        // N and S both want east; one is deflected west.
        resetDut("rst3");
`ifdef MINBD_AGE_EN
        pushMesh(0, mk(2, 1, 1, 'h31), 0, mk(2, 1, 2, 'h32), 1);
`else
        pushMesh(0, mk(2, 1, 1, 'h32), 0, mk(2, 1, 1, 'h31), 1);
`endif
        applyStimulus(mk(2, 1, 1, 'h31), 0, mk(2, 1, 1, 'h32), 0, 1'b0, 0, 1'b0, 1'b0, "t3");
        idle(3);

        // In-flight flits discarded by reset; counter cleared.
        applyStimulus(mk(2, 1, 1, 'h31), 0, mk(2, 1, 1, 'h32), 0, 1'b0, 0, 1'b0, 1'b0, "t6");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_valids", {nxt[15], ext[15], sxt[15], wxt[15], ej_valid}, 0);
        checkOutput("t6_defl", defl_cnt, 0);
        rst = 1'b0;
        idle(3);
        checkOutput("t7_idle_valids", {nxt[15], ext[15], sxt[15], wxt[15], ej_valid}, 0);

        // All four ports busy: injection refused, every flit productive.
        resetDut("rst4");
        pushMesh(mk(1, 2, 0, 'h41), mk(2, 1, 0, 'h42), mk(1, 0, 0, 'h43), mk(0, 1, 0, 'h44), 0);
        applyStimulus(mk(1, 2, 0, 'h41), mk(2, 1, 0, 'h42), mk(1, 0, 0, 'h43), mk(0, 1, 0, 'h44),
                      1'b1, mk(1, 2, 0, 'h4F), 1'b1, 1'b0, "t4");
        idle(3);

        // W empty: injected northbound flit takes W slot and reaches nxt.
        resetDut("rst5");
        pushMesh(mk(1, 2, 0, 'h5F), mk(2, 1, 0, 'h52), mk(1, 0, 0, 'h51), mk(0, 1, 0, 'h53), 0);
        applyStimulus(mk(1, 0, 0, 'h51), mk(2, 1, 0, 'h52), mk(0, 1, 0, 'h53), 0,
                      1'b1, mk(1, 2, 0, 'h5F), 1'b1, 1'b1, "t5");
        idle(3);

        // Ejection frees N slot for injection in the same cycle.
        resetDut("rst8");
        ejQ.push_back(mk(1, 1, 4, 'h81));
        pushMesh(mk(1, 2, 0, 'h8F), mk(2, 1, 0, 'h82), mk(1, 0, 0, 'h83), mk(0, 1, 0, 'h84), 0);
        applyStimulus(mk(1, 1, 4, 'h81), mk(2, 1, 0, 'h82), mk(1, 0, 0, 'h83), mk(0, 1, 0, 'h84),
                      1'b1, mk(1, 2, 0, 'h8F), 1'b1, 1'b1, "t8");
        idle(3);

        // Injected flit gets valid forced on and age forced to zero.
        resetDut("rst9");
        pushMesh(0, 0, 0, mk(0, 1, 0, 'hA5), 0);
        applyStimulus(0, 0, 0, 0, 1'b1, {1'b0, 2'd1, 2'd0, 3'd7, 8'hA5}, 1'b1, 1'b1, "t9");
        idle(3);

        checkOutput("ejQ_left", ejQ.size(), 0);
        checkOutput("meshQ_left", meshQ.size(), 0);

        // Four local flits per cycle: three deflections each, then saturation.
        resetDut("rst10");
        monOn = 1'b0;
        for (int c = 0; c < 10; c++) begin
            nty = mk(1, 1, 0, 1); ety = mk(1, 1, 0, 2);
            sty = mk(1, 1, 0, 3); wty = mk(1, 1, 0, 4);
            @(negedge clk);
        end
        nty = '0; ety = '0; sty = '0; wty = '0;
        idle(3);
        checkOutput("defl_count30", defl_cnt, 30);
        for (int c = 0; c < 21840; c++) begin
            nty = mk(1, 1, 0, 1); ety = mk(1, 1, 0, 2);
            sty = mk(1, 1, 0, 3); wty = mk(1, 1, 0, 4);
            @(negedge clk);
        end
        nty = '0; ety = '0; sty = '0; wty = '0;
        idle(3);
        checkOutput("defl_saturate", defl_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
